// File: rtl/evdev_pkg.sv
// evdev_pkg: shared types and sizing helpers for the keyboard-event display
// scheduler (evdev_disp_sched, ev_fifo, evdev_disp_if).
//   evdev_t      - one 32-bit keyboard event word
//   disp_state_t - display scheduler FSM states
package evdev_pkg;

    typedef logic [31:0] evdev_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } disp_state_t;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..n-1; at least one bit so a one-cycle
    // dwell still gets a legal counter vector.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/evdev_disp_sched_if.sv
// evdev_disp_if: event-in / display-out bundle of the display scheduler.
//   ev_data, ev_valid           - keyboard event word and its one-cycle strobe
//   val, blank                  - value for seven_seg and display-dark flag
//   pending, overflow           - FIFO occupancy and sticky drop flag
// Modports: master = event producer / display consumer, slave = scheduler.
interface evdev_disp_if #(
    parameter int DEPTH = 8
);
    import evdev_pkg::*;

    evdev_t                       ev_data;
    logic                         ev_valid;
    evdev_t                       val;
    logic                         blank;
    logic [$clog2(DEPTH+1)-1:0]   pending;
    logic                         overflow;

    modport master (
        output ev_data, ev_valid,
        input  val, blank, pending, overflow
    );

    modport slave (
        input  ev_data, ev_valid,
        output val, blank, pending, overflow
    );

endinterface

// File: rtl/ev_fifo.sv
// ev_fifo: single-clock pointer-based FIFO of keyboard events.
//   clk, rst    - clock, synchronous active-high reset (empties the FIFO)
//   push, din   - write request and data; accepted when not full, or when
//                 full but a pop happens in the same cycle
//   pop, dout   - read request; dout always shows the head entry so the
//                 consumer can capture it on the popping edge
//   count       - registered occupancy; full/empty decoded from it
module ev_fifo
    import evdev_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  evdev_t                      din,
    input  logic                        pop,
    output evdev_t                      dout,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        full,
    output logic                        empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    evdev_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset: only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/evdev_disp_sched.sv
// evdev_disp_sched: queues keyboard events and holds each one on the
// seven-segment value bus for DWELL_CYCLES clocks so bursts stay readable.
//   clk_100mhz  - system clock
//   rst         - synchronous active-high reset (idle, FIFO empty, outputs 0)
//   bus         - evdev_disp_if slave: ev_data/ev_valid in; val, blank,
//                 pending, overflow out
// Optional feature: define EVDEV_DISP_BLANK_EN to insert BLANK_CYCLES of dark
// display between back-to-back events so repeated keys are distinguishable.
// Without it blank is tied low and BLANK_CYCLES has no effect.
module evdev_disp_sched
    import evdev_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int BLANK_CYCLES = 5_000_000
) (
    input  logic           clk_100mhz,
    input  logic           rst,
    evdev_disp_if.slave    bus
);
`ifdef EVDEV_DISP_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam int CNT_MAX = BLANK_EN ? max_i(DWELL_CYCLES, BLANK_CYCLES)
                                      : DWELL_CYCLES;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);

    disp_state_t   state;
    logic [CNT_W-1:0] cnt;
    evdev_t        val_r;
    logic          blank_r;
    logic          overflow_r;

    logic          pop;
    evdev_t        head;
    logic          full;
    logic          empty;

    ev_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_100mhz),
        .rst   (rst),
        .push  (bus.ev_valid),
        .din   (bus.ev_data),
        .pop   (pop),
        .dout  (head),
        .count (bus.pending),
        .full  (full),
        .empty (empty)
    );

    // Pop decision mirrors the FSM transitions that load val from the FIFO.
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !empty;
            SHOW:    pop = (cnt == '0) && !empty && !BLANK_EN;
            BLANK:   pop = (cnt == '0);
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            val_r      <= '0;
            blank_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            // A push into a full FIFO is lost unless a pop frees a slot now.
            if (bus.ev_valid && full && !pop)
                overflow_r <= 1'b1;

            case (state)
                IDLE: begin
                    if (!empty) begin
                        val_r <= head;
                        cnt   <= DWELL_LD;
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (empty) begin
                        state <= IDLE;
`ifdef EVDEV_DISP_BLANK_EN
                    end else begin
                        cnt     <= BLANK_LD;
                        blank_r <= 1'b1;
                        state   <= BLANK;
                    end
`else
                    end else begin
                        val_r <= head;
                        cnt   <= DWELL_LD;
                    end
`endif
                end
`ifdef EVDEV_DISP_BLANK_EN
                BLANK: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        val_r   <= head;
                        cnt     <= DWELL_LD;
                        blank_r <= 1'b0;
                        state   <= SHOW;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.val      = val_r;
    assign bus.blank    = blank_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_evdev_disp_sched.sv
// Bench for evdev_disp_sched with DEPTH=4, DWELL_CYCLES=4, BLANK_CYCLES=2.
// A queue-based model predicts every output each cycle; directed sequences
// add literal expectations for the documented timing cases.
module tb_evdev_disp_sched;
    import evdev_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DWELL  = 4;
    localparam int BLANKC = 2;
`ifdef EVDEV_DISP_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    evdev_disp_if #(.DEPTH(DEPTH)) bus ();

    evdev_disp_sched #(
        .DEPTH        (DEPTH),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANKC)
    ) dut (
        .clk_100mhz (clk),
        .rst        (rst),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: what the outputs must be after the edges seen so far.
    evdev_t  mq[$];
    evdev_t  m_val     = '0;
    bit      m_blank   = 1'b0;
    bit      m_ovf     = 1'b0;
    bit      m_ready   = 1'b0;
    bit      blanking  = 1'b0;
    longint  mc        = 0;
    longint  last_pop  = -1000;
    longint  blank_end = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Advance the model across one rising edge, given the inputs it samples.
    // Rules: an event may be popped once the previous one has been shown for
    // DWELL cycles; with blanking, a back-to-back pop is delayed by BLANKC
    // dark cycles; a push into a full queue is dropped unless a pop coincides.
    task automatic model_step(input bit r, input bit v, input evdev_t d);
        bit pop;
        int sz;
        mc++;
        if (r) begin
            mq.delete();
            m_val    = '0;
            m_blank  = 1'b0;
            m_ovf    = 1'b0;
            blanking = 1'b0;
            last_pop = -1000;
            m_ready  = 1'b1;
            return;
        end
        if (!m_ready)
            return;
        sz  = mq.size();
        pop = 1'b0;
        if (blanking) begin
            if (mc == blank_end)
                pop = 1'b1;
        end else if (sz > 0 && mc >= last_pop + DWELL) begin
            if (BLANK_ON && mc == last_pop + DWELL) begin
                blanking  = 1'b1;
                blank_end = mc + BLANKC;
                m_blank   = 1'b1;
            end else begin
                pop = 1'b1;
            end
        end
        if (pop) begin
            m_val    = mq.pop_front();
            last_pop = mc;
            blanking = 1'b0;
            m_blank  = 1'b0;
        end
        if (v) begin
            if (sz < DEPTH || pop)
                mq.push_back(d);
            else
                m_ovf = 1'b1;
        end
    endtask

    // Compare on the falling edge, then predict the next rising edge.
    always @(negedge clk) begin
        if (m_ready) begin
            chk("model_val",      bus.val,               m_val);
            chk("model_blank",    32'(bus.blank),        32'(m_blank));
            chk("model_pending",  32'(bus.pending),      32'(mq.size()));
            chk("model_overflow", 32'(bus.overflow),     32'(m_ovf));
        end
        model_step(rst, bus.ev_valid, bus.ev_data);
    end

    task automatic cyc(input bit r, input bit v, input evdev_t d);
        @(posedge clk);
        #1;
        rst          = r;
        bus.ev_valid = v;
        bus.ev_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
    endtask

    initial begin
        bus.ev_valid = 1'b0;
        bus.ev_data  = '0;

        // Reset state, and quiet after release.
        do_reset();
        idle(1);
        @(negedge clk);
        chk("rst_val",      bus.val,            32'h0);
        chk("rst_pending",  32'(bus.pending),   32'h0);
        chk("rst_overflow", 32'(bus.overflow),  32'h0);
        idle(5);
        @(negedge clk);
        chk("quiet_val",    bus.val,            32'h0);
        chk("quiet_blank",  32'(bus.blank),     32'h0);

        // Single event: shown two cycles after its strobe, then held.
        do_reset();
        cyc(1'b0, 1'b1, 32'hDEADBEEF);          // cycle 0
        idle(1);                                // cycle 1
        @(negedge clk);
        chk("single_pending_c1", 32'(bus.pending), 32'd1);
        idle(1);                                // cycle 2
        @(negedge clk);
        chk("single_val_c2",     bus.val,          32'hDEADBEEF);
        chk("single_pending_c2", 32'(bus.pending), 32'd0);
        idle(8);
        @(negedge clk);
        chk("single_val_hold",   bus.val,          32'hDEADBEEF);

        // Three back-to-back events.
        do_reset();
        cyc(1'b0, 1'b1, 32'h0000_00AA);         // cycle 0
        cyc(1'b0, 1'b1, 32'h0000_00BB);         // cycle 1
        cyc(1'b0, 1'b1, 32'h0000_00CC);         // cycle 2
        idle(3);                                // cycle 5
        @(negedge clk);
        chk("abc_val_c5", bus.val, 32'h0000_00AA);
        if (BLANK_ON) begin
            idle(1);                            // cycle 6
            @(negedge clk);
            chk("abc_blank_c6",  32'(bus.blank), 32'd1);
            chk("abc_valA_c6",   bus.val,        32'h0000_00AA);
            idle(1);                            // cycle 7
            @(negedge clk);
            chk("abc_blank_c7",  32'(bus.blank), 32'd1);
            idle(1);                            // cycle 8
            @(negedge clk);
            chk("abc_valB_c8",   bus.val,        32'h0000_00BB);
            chk("abc_blank_c8",  32'(bus.blank), 32'd0);
            idle(6);                            // cycle 14
            @(negedge clk);
            chk("abc_valC_c14",  bus.val,        32'h0000_00CC);
        end else begin
            idle(1);                            // cycle 6
            @(negedge clk);
            chk("abc_valB_c6",   bus.val,        32'h0000_00BB);
            idle(3);                            // cycle 9
            @(negedge clk);
            chk("abc_valB_c9",   bus.val,        32'h0000_00BB);
            idle(1);                            // cycle 10
            @(negedge clk);
            chk("abc_valC_c10",  bus.val,        32'h0000_00CC);
        end
        idle(12);

        // Burst of seven events into a four-deep queue. Without blanking the
        // pop at the end of cycle 5 frees a slot for E5, so E6 is the drop;
        // with blanking that pop is deferred and E5 is dropped.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1, 32'hE000_0000 + 32'(i));
            if (i == 5) begin
                @(negedge clk);
                chk("burst_pending_peak", 32'(bus.pending), 32'd4);
            end
            if (i == 6) begin
                @(negedge clk);
                chk("burst_ovf_c6", 32'(bus.overflow), BLANK_ON ? 32'd1 : 32'd0);
            end
        end
        idle(1);                                // cycle 7
        @(negedge clk);
        chk("burst_ovf_c7", 32'(bus.overflow), 32'd1);
        idle(45);

        // Reset mid-dwell with two events pending.
        do_reset();
        cyc(1'b0, 1'b1, 32'h0000_0001);         // cycle 0
        cyc(1'b0, 1'b1, 32'h0000_0002);         // cycle 1
        cyc(1'b0, 1'b1, 32'h0000_0003);         // cycle 2
        cyc(1'b1, 1'b0, '0);                    // cycle 3, reset sampled here
        @(negedge clk);
        chk("rstmid_pending_before", 32'(bus.pending), 32'd2);
        idle(1);                                // cycle 4
        @(negedge clk);
        chk("rstmid_val",      bus.val,           32'h0);
        chk("rstmid_pending",  32'(bus.pending),  32'd0);
        chk("rstmid_overflow", 32'(bus.overflow), 32'd0);
        cyc(1'b0, 1'b1, 32'h0000_0012);         // cycle 5
        idle(1);                                // cycle 6
        @(negedge clk);
        chk("rstmid_val_c6", bus.val, 32'h0);
        idle(1);                                // cycle 7
        @(negedge clk);
        chk("rstmid_val_c7", bus.val, 32'h0000_0012);
        idle(6);

        // Event arriving on the last dwell cycle with an empty queue.
        do_reset();
        cyc(1'b0, 1'b1, 32'h0000_00A1);         // cycle 0
        idle(4);                                // cycle 4
        cyc(1'b0, 1'b1, 32'h0000_00B2);         // cycle 5
        @(negedge clk);
        chk("late_val_c5", bus.val, 32'h0000_00A1);
        idle(1);                                // cycle 6
        @(negedge clk);
        chk("late_val_c6",     bus.val,          32'h0000_00A1);
        chk("late_pending_c6", 32'(bus.pending), 32'd1);
        idle(1);                                // cycle 7
        @(negedge clk);
        chk("late_val_c7", bus.val, 32'h0000_00B2);
        idle(6);

        // Randomized traffic, alternating bursty and sparse phases, with rare
        // resets; checked every cycle by the model.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            bit r;
            bit v;
            r = ($urandom_range(0, 399) == 0);
            if (((k / 200) % 2) == 0)
                v = ($urandom_range(0, 1) == 0);
            else
                v = ($urandom_range(0, 7) == 0);
            cyc(r, v, evdev_t'($urandom));
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
